// File: rtl/gshare_bht_pkg.sv
// Shared frontend branch-predictor types and helpers: saturating counter
// arithmetic and the geometry derivations used by the BHT and BTB.
package gshare_bht_pkg;

    // Widest counter any predictor table may use; narrower tables zero-extend into it.
    localparam int unsigned BP_CTR_MAX_BITS = 4;

    typedef logic [BP_CTR_MAX_BITS-1:0] bp_ctr_t;

    function automatic int unsigned bp_offset(input bit rvc);
        return rvc ? 1 : 2;
    endfunction

    function automatic int unsigned bp_row_addr(input int unsigned instr_per_fetch);
        return $clog2(instr_per_fetch);
    endfunction

    function automatic int unsigned bp_row_bits(input int unsigned instr_per_fetch);
        return (instr_per_fetch > 1) ? $clog2(instr_per_fetch) : 1;
    endfunction

    function automatic int unsigned bp_idx_bits(input int unsigned nr_entries,
                                                input int unsigned instr_per_fetch);
        return $clog2(nr_entries / instr_per_fetch);
    endfunction

    // Saturating up/down step of a counter that is 'bits' wide.
    function automatic bp_ctr_t sat_ctr_next(input bp_ctr_t ctr, input logic taken,
                                             input int unsigned bits);
        bp_ctr_t max_v;
        max_v = bp_ctr_t'((1 << bits) - 1);
        if (taken) begin
            return (ctr >= max_v) ? max_v : ctr + bp_ctr_t'(1);
        end
        return (ctr == '0) ? '0 : ctr - bp_ctr_t'(1);
    endfunction

endpackage

// File: rtl/bp_init_sweep.sv
// Row-by-row table init/flush sequencer: walks every row once after reset or
// flush, then reports ready. Shared by the BHT and BTB.
module bp_init_sweep #(
    parameter  int unsigned ROWS  = 512,
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_flush,
    output logic             o_ready,
    output logic             o_sweep_we,
    output logic [ROW_W-1:0] o_sweep_row
);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic [0:0]       r_state;
    logic [ROW_W-1:0] r_row;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_INIT;
            r_row   <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    // A flush mid-sweep restarts from row 0 so no row is left stale.
                    if (i_flush) begin
                        r_row <= '0;
                    end else if (r_row == LAST_ROW) begin
                        r_state <= ST_READY;
                        r_row   <= '0;
                    end else begin
                        r_row <= r_row + ROW_W'(1);
                    end
                end
                ST_READY: begin
                    if (i_flush) begin
                        r_state <= ST_INIT;
                        r_row   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_row   <= '0;
                end
            endcase
        end
    end

    assign o_ready     = (r_state == ST_READY);
    assign o_sweep_we  = (r_state == ST_INIT);
    assign o_sweep_row = r_row;

endmodule

// File: rtl/gshare_bht.sv
// Gshare branch history table: PC index XOR speculative global history selects
// a row of INSTR_PER_FETCH saturating counters. Storage is reset-free.
module gshare_bht
    import gshare_bht_pkg::*;
#(
    parameter  int unsigned VLEN            = 64,
    parameter  int unsigned INSTR_PER_FETCH = 2,
    parameter  bit          RVC             = 1'b1,
    parameter  int unsigned NR_ENTRIES      = 1024,
    parameter  int unsigned CTR_BITS        = 2,
    parameter  int unsigned HIST_LEN        = 8,
    parameter  bit          DEBUG_EN        = 1'b1,
    localparam int unsigned IDX_BITS        = bp_idx_bits(NR_ENTRIES, INSTR_PER_FETCH),
    localparam int unsigned ROW_BITS        = bp_row_bits(INSTR_PER_FETCH)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_bp_i,
    input  logic                       debug_mode_i,
    input  logic [VLEN-1:0]            vpc_i,
    input  logic                       ghr_shift_i,
    input  logic                       ghr_shift_taken_i,
    input  logic                       update_valid_i,
    input  logic [IDX_BITS-1:0]        update_index_i,
    input  logic [ROW_BITS-1:0]        update_row_i,
    input  logic                       update_taken_i,
    input  logic                       update_mispredict_i,
    input  logic [HIST_LEN-1:0]        update_ghr_i,
    output logic [INSTR_PER_FETCH-1:0] valid_o,
    output logic [INSTR_PER_FETCH-1:0] taken_o,
    output logic [IDX_BITS-1:0]        index_o,
    output logic [HIST_LEN-1:0]        ghr_o,
    output logic                       ready_o
);

    localparam int unsigned ROWS     = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned OFFSET   = bp_offset(RVC);
    localparam int unsigned ROW_ADDR = bp_row_addr(INSTR_PER_FETCH);
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));

    // Table storage
    logic [INSTR_PER_FETCH-1:0]               r_valid [ROWS];
    logic [INSTR_PER_FETCH-1:0][CTR_BITS-1:0] r_ctr   [ROWS];
    logic [HIST_LEN-1:0]                      r_ghr;

    logic                                     w_ready;
    logic                                     w_sweep_we;
    logic [IDX_BITS-1:0]                      w_sweep_row;
    logic [IDX_BITS-1:0]                      w_pc_idx;
    logic [IDX_BITS-1:0]                      w_index;
    logic [INSTR_PER_FETCH-1:0]               w_rd_valid;
    logic [INSTR_PER_FETCH-1:0][CTR_BITS-1:0] w_rd_ctr;
    logic [INSTR_PER_FETCH-1:0]               w_rd_taken;
    logic [ROW_BITS-1:0]                      w_col;
    logic [CTR_BITS-1:0]                      w_cur_ctr;
    logic [CTR_BITS-1:0]                      w_ctr_next;
    logic                                     w_train;
    logic [HIST_LEN-1:0]                      w_ghr_restore;
    logic [HIST_LEN-1:0]                      w_ghr_shift;
    logic [HIST_LEN-1:0]                      w_ghr_d;
    logic                                     w_unused;

    bp_init_sweep #(
        .ROWS (ROWS)
    ) i_sweep (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_flush     (flush_bp_i),
        .o_ready     (w_ready),
        .o_sweep_we  (w_sweep_we),
        .o_sweep_row (w_sweep_row)
    );

    assign w_pc_idx = vpc_i[IDX_BITS+ROW_ADDR+OFFSET-1 -: IDX_BITS];
    assign w_index  = w_pc_idx ^ IDX_BITS'(r_ghr);

    // Prediction read
    assign w_rd_valid = r_valid[w_index];
    assign w_rd_ctr   = r_ctr[w_index];

    for (genvar c = 0; c < INSTR_PER_FETCH; c++) begin : g_col
        assign w_rd_taken[c] = w_rd_ctr[c][CTR_BITS-1];
    end

    assign valid_o = w_rd_valid & {INSTR_PER_FETCH{w_ready}};
    assign taken_o = w_rd_taken & {INSTR_PER_FETCH{w_ready}};
    assign index_o = w_index;
    assign ghr_o   = r_ghr;
    assign ready_o = w_ready;

    // Training
    if (INSTR_PER_FETCH > 1) begin : g_col_sel
        assign w_col = update_row_i;
    end else begin : g_col_one
        assign w_col = '0;
    end

    assign w_train    = update_valid_i & w_ready & ~(DEBUG_EN & debug_mode_i);
    assign w_cur_ctr  = r_ctr[update_index_i][w_col];
    assign w_ctr_next = CTR_BITS'(sat_ctr_next(bp_ctr_t'(w_cur_ctr), update_taken_i, CTR_BITS));

    // Sweep write is placed last so it always wins over a stray training write.
    always_ff @(posedge clk_i) begin
        if (w_train) begin
            r_valid[update_index_i][w_col] <= 1'b1;
            r_ctr[update_index_i][w_col]   <= w_ctr_next;
        end
        if (w_sweep_we) begin
            r_valid[w_sweep_row] <= '0;
            r_ctr[w_sweep_row]   <= {INSTR_PER_FETCH{CTR_INIT}};
        end
    end

    // Global history
    if (HIST_LEN > 1) begin : g_hist
        assign w_ghr_restore = {update_ghr_i[HIST_LEN-2:0], update_taken_i};
        assign w_ghr_shift   = {r_ghr[HIST_LEN-2:0], ghr_shift_taken_i};
    end else begin : g_hist_one
        assign w_ghr_restore = update_taken_i;
        assign w_ghr_shift   = ghr_shift_taken_i;
    end

    // Restore beats shift: a mispredict redirects fetch, so the younger shift is wrong-path.
    always_comb begin
        w_ghr_d = r_ghr;
        if (!w_ready || flush_bp_i) begin
            w_ghr_d = '0;
        end else if (update_valid_i && update_mispredict_i) begin
            w_ghr_d = w_ghr_restore;
        end else if (ghr_shift_i) begin
            w_ghr_d = w_ghr_shift;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ghr <= '0;
        end else begin
            r_ghr <= w_ghr_d;
        end
    end

    assign w_unused = ^{vpc_i, update_ghr_i, update_row_i};

endmodule

// File: tb/tb_gshare_bht.sv
// Scoreboarded bench for gshare_bht on a 16-entry, 2-column, 3-bit-history table.
module tb_gshare_bht;

    localparam int unsigned VLEN = 64;
    localparam int unsigned IPF  = 2;
    localparam int unsigned IDXB = 3;
    localparam int unsigned HL   = 3;

    localparam int SEL_VALID = 0;
    localparam int SEL_TAKEN = 1;
    localparam int SEL_INDEX = 2;
    localparam int SEL_GHR   = 3;
    localparam int SEL_READY = 4;

    logic            clk_i;
    logic            rst_ni;
    logic            flush_bp_i;
    logic            debug_mode_i;
    logic [VLEN-1:0] vpc_i;
    logic            ghr_shift_i;
    logic            ghr_shift_taken_i;
    logic            update_valid_i;
    logic [IDXB-1:0] update_index_i;
    logic [0:0]      update_row_i;
    logic            update_taken_i;
    logic            update_mispredict_i;
    logic [HL-1:0]   update_ghr_i;
    logic [IPF-1:0]  valid_o;
    logic [IPF-1:0]  taken_o;
    logic [IDXB-1:0] index_o;
    logic [HL-1:0]   ghr_o;
    logic            ready_o;

    gshare_bht #(
        .VLEN            (VLEN),
        .INSTR_PER_FETCH (IPF),
        .RVC             (1'b1),
        .NR_ENTRIES      (16),
        .CTR_BITS        (2),
        .HIST_LEN        (HL),
        .DEBUG_EN        (1'b1)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_bp_i          (flush_bp_i),
        .debug_mode_i        (debug_mode_i),
        .vpc_i               (vpc_i),
        .ghr_shift_i         (ghr_shift_i),
        .ghr_shift_taken_i   (ghr_shift_taken_i),
        .update_valid_i      (update_valid_i),
        .update_index_i      (update_index_i),
        .update_row_i        (update_row_i),
        .update_taken_i      (update_taken_i),
        .update_mispredict_i (update_mispredict_i),
        .update_ghr_i        (update_ghr_i),
        .valid_o             (valid_o),
        .taken_o             (taken_o),
        .index_o             (index_o),
        .ghr_o               (ghr_o),
        .ready_o             (ready_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            SEL_VALID: return 32'(valid_o);
            SEL_TAKEN: return 32'(taken_o);
            SEL_INDEX: return 32'(index_o);
            SEL_GHR:   return 32'(ghr_o);
            default:   return 32'(ready_o);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Sample on the falling edge, then advance to just past the next rising edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk_i);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sel), e.exp);
        end
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [VLEN-1:0] pc_of(input int p);
        return VLEN'(p) << 2;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] msb_seq;
        logic [2:0] shift_seq;
        logic [2:0] ghr_seq [3];

        rst_ni              = 1'b0;
        flush_bp_i          = 1'b0;
        debug_mode_i        = 1'b0;
        vpc_i               = pc_of(3);
        ghr_shift_i         = 1'b0;
        ghr_shift_taken_i   = 1'b0;
        update_valid_i      = 1'b0;
        update_index_i      = '0;
        update_row_i        = '0;
        update_taken_i      = 1'b0;
        update_mispredict_i = 1'b0;
        update_ghr_i        = '0;

        repeat (2) @(posedge clk_i);
        #1;
        sb_push("rst_ready", SEL_READY, 32'd0);
        sb_push("rst_valid", SEL_VALID, 32'd0);
        sb_push("rst_taken", SEL_TAKEN, 32'd0);
        sb_push("rst_ghr",   SEL_GHR,   32'd0);
        sb_push("rst_index", SEL_INDEX, 32'd3);
        cyc();

        // 1: init sweep after reset release
        rst_ni = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sb_push("init_ready", SEL_READY, 32'd0);
            if (k == 0 || k == 7) begin
                sb_push("init_valid", SEL_VALID, 32'd0);
                sb_push("init_taken", SEL_TAKEN, 32'd0);
            end
            cyc();
        end
        sb_push("ready_c8", SEL_READY, 32'd1);
        cyc();
        for (int p = 0; p < 8; p += 3) begin
            vpc_i = pc_of(p);
            sb_push("post_init_index", SEL_INDEX, 32'(p));
            sb_push("post_init_valid", SEL_VALID, 32'd0);
            sb_push("post_init_taken", SEL_TAKEN, 32'd3);
            cyc();
        end

        // 2: saturating training on index 5, column 1 (MSB after each step)
        vpc_i   = pc_of(5);
        msb_seq = 6'b001111;
        for (int i = 0; i < 6; i++) begin
            update_valid_i      = 1'b1;
            update_index_i      = 3'd5;
            update_row_i        = 1'b1;
            update_taken_i      = (i < 3);
            update_mispredict_i = 1'b0;
            cyc();
            update_valid_i = 1'b0;
            sb_push("train_msb", SEL_TAKEN, {30'd0, msb_seq[i], 1'b1});
            cyc();
        end
        sb_push("train_valid", SEL_VALID, 32'b10);
        sb_push("train_ghr",   SEL_GHR,   32'd0);
        cyc();

        // 3: speculative shifts 1,0,1
        vpc_i      = pc_of(3);
        shift_seq  = 3'b101;
        ghr_seq[0] = 3'b001;
        ghr_seq[1] = 3'b010;
        ghr_seq[2] = 3'b101;
        for (int i = 0; i < 3; i++) begin
            ghr_shift_i       = 1'b1;
            ghr_shift_taken_i = shift_seq[2-i];
            cyc();
            ghr_shift_i = 1'b0;
            sb_push("shift_ghr", SEL_GHR, 32'(ghr_seq[i]));
            cyc();
        end
        sb_push("hash_index", SEL_INDEX, 32'b110);
        cyc();

        // 4: restore wins over same-cycle shift
        update_valid_i      = 1'b1;
        update_mispredict_i = 1'b1;
        update_ghr_i        = 3'b011;
        update_taken_i      = 1'b0;
        update_index_i      = 3'd7;
        update_row_i        = 1'b0;
        ghr_shift_i         = 1'b1;
        ghr_shift_taken_i   = 1'b1;
        cyc();
        update_valid_i      = 1'b0;
        update_mispredict_i = 1'b0;
        ghr_shift_i         = 1'b0;
        sb_push("restore_ghr", SEL_GHR, 32'b110);
        cyc();

        // 5: debug mode blocks training but not the restore
        debug_mode_i        = 1'b1;
        update_valid_i      = 1'b1;
        update_mispredict_i = 1'b1;
        update_index_i      = 3'd2;
        update_row_i        = 1'b0;
        update_taken_i      = 1'b1;
        update_ghr_i        = 3'b010;
        cyc();
        debug_mode_i        = 1'b0;
        update_valid_i      = 1'b0;
        update_mispredict_i = 1'b0;
        vpc_i               = pc_of(7);
        sb_push("dbg_ghr",   SEL_GHR,   32'b101);
        sb_push("dbg_index", SEL_INDEX, 32'd2);
        sb_push("dbg_valid", SEL_VALID, 32'd0);
        sb_push("dbg_taken", SEL_TAKEN, 32'b11);
        cyc();

        // 6: flush, re-flush mid-sweep, updates dropped during INIT
        flush_bp_i = 1'b1;
        sb_push("flush_cycle_ready", SEL_READY, 32'd1);
        cyc();
        for (int j = 1; j <= 4; j++) begin
            flush_bp_i        = (j == 4);
            ghr_shift_i       = (j == 2);
            ghr_shift_taken_i = 1'b1;
            sb_push("flush_ready", SEL_READY, 32'd0);
            sb_push("flush_ghr",   SEL_GHR,   32'd0);
            cyc();
        end
        flush_bp_i  = 1'b0;
        ghr_shift_i = 1'b0;
        for (int j = 0; j < 8; j++) begin
            update_valid_i = (j >= 6);
            update_index_i = 3'd0;
            update_row_i   = 1'b0;
            update_taken_i = 1'b0;
            sb_push("reflush_ready", SEL_READY, 32'd0);
            cyc();
        end
        update_valid_i = 1'b0;
        sb_push("reflush_done", SEL_READY, 32'd1);
        sb_push("reflush_ghr",  SEL_GHR,   32'd0);
        cyc();
        for (int p = 0; p < 8; p++) begin
            vpc_i = pc_of(p);
            sb_push("flushed_index", SEL_INDEX, 32'(p));
            sb_push("flushed_valid", SEL_VALID, 32'd0);
            sb_push("flushed_taken", SEL_TAKEN, 32'b11);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/gshare_bht.md
Name: gshare_bht

Overview:
- Parametrised successor to the frontend bimodal BHT: a gshare predictor with INSTR_PER_FETCH counter columns per row and configurable counter width.
- The row index is PC index bits XOR a speculative global history register (GHR).
- Table storage has no reset. A row-by-row init/flush sweep FSM initialises it, so the storage can map to SRAM.
- Sits in the frontend beside the BTB. The FTQ saves index_o and ghr_o at prediction time and returns them with the resolved branch.

Parameters:
- VLEN, 64, virtual address width.
- INSTR_PER_FETCH, 2, counter columns per row (power of 2).
- RVC, 1, compressed ISA enabled; OFFSET=1 if set, else 2.
- NR_ENTRIES, 1024, total counters; ROWS=NR_ENTRIES/INSTR_PER_FETCH; IDX_BITS=$clog2(ROWS).
- CTR_BITS, 2, saturating counter width, 1..4.
- HIST_LEN, 8, GHR length, 1..IDX_BITS.
- DEBUG_EN, 1, suppress counter training in debug mode.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_bp_i  in  1  invalidate the table; starts the init sweep
- debug_mode_i  in  1  core is in debug mode
- vpc_i  in  VLEN  fetch virtual PC
- ghr_shift_i  in  1  a predicted conditional branch is being fetched
- ghr_shift_taken_i  in  1  predicted direction to shift into the GHR
- update_valid_i  in  1  a resolved conditional branch is presented
- update_index_i  in  IDX_BITS  index saved at prediction time
- update_row_i  in  ROW_BITS  column within the row; ROW_BITS=max(1,$clog2(INSTR_PER_FETCH))
- update_taken_i  in  1  resolved direction
- update_mispredict_i  in  1  direction was mispredicted
- update_ghr_i  in  HIST_LEN  GHR checkpoint saved at prediction time
- valid_o  out  INSTR_PER_FETCH  per-column counter valid
- taken_o  out  INSTR_PER_FETCH  per-column prediction (counter MSB)
- index_o  out  IDX_BITS  hashed index, for the FTQ
- ghr_o  out  HIST_LEN  current GHR, for the FTQ checkpoint
- ready_o  out  1  table initialised; predictions and updates active

Behaviour:
- Index hash:
  - pc_idx = vpc_i[IDX_BITS+ROW_ADDR+OFFSET-1 : ROW_ADDR+OFFSET], with ROW_ADDR=$clog2(INSTR_PER_FETCH).
  - index_o = pc_idx XOR zero-extended ghr_q. Purely combinational.
- Prediction (combinational, same cycle):
  - valid_o[i] = entry[index_o][i].valid AND ready_o.
  - taken_o[i] = entry[index_o][i].ctr[CTR_BITS-1] AND ready_o.
- FSM states: INIT, READY.
  - Reset: state=INIT, sweep counter=0, ghr_q=0.
  - INIT, each cycle: row[sweep] gets valid=0 and ctr=2^(CTR_BITS-1) (weakly taken) in every column; sweep increments.
  - INIT → READY on the edge that writes row ROWS-1. ready_o is high from the ROWSth cycle after reset deassertion.
  - READY + flush_bp_i → INIT with sweep=0 and ghr_q=0.
  - INIT + flush_bp_i → sweep restarts at 0.
  - An async reset asserted mid-sweep returns to INIT with sweep=0.
- Counter training:
  - Trains when update_valid_i AND ready_o AND NOT (DEBUG_EN AND debug_mode_i).
  - The entry at [update_index_i][update_row_i] gets valid=1. The counter increments if taken and saturates at 2^CTR_BITS-1; it decrements if not taken and saturates at 0.
  - The write lands on the next edge. A same-index read sees the new value the following cycle; there is no bypass.
  - Updates during INIT are dropped.
- GHR update, priority order:
  - (1) Not ready_o or flush_bp_i: ghr_q ← 0.
  - (2) update_valid_i AND update_mispredict_i: ghr_q ← {update_ghr_i[HIST_LEN-2:0], update_taken_i}. This applies even in debug mode. For HIST_LEN=1: ghr_q ← update_taken_i.
  - (3) ghr_shift_i: ghr_q ← {ghr_q[HIST_LEN-2:0], ghr_shift_taken_i}.
  - (4) Otherwise: hold.
  - A restore wins over a same-cycle shift; that shift is discarded, since the fetch is being redirected.
- Reset values: valid_o=0, taken_o=0, ready_o=0, ghr_o=0. index_o = pc_idx, since ghr_q=0.

Decomposition:
- Shared frontend package:
  - bp_ctr_t width derived from CTR_BITS.
  - A function sat_ctr_next(ctr, taken) implementing saturating increment/decrement, reusable by the future tournament chooser.
  - Localparam derivation helpers for OFFSET, ROW_ADDR and IDX_BITS.
- One sub-module: bp_init_sweep, containing the INIT/READY FSM, the sweep counter and the flush restart. Outputs are ready, sweep_we and sweep_row. It is also reused by the BTB.
- Table and GHR logic live in gshare_bht.

Test Plan:
Configuration for all tests: NR_ENTRIES=16, INSTR_PER_FETCH=2, HIST_LEN=3, CTR_BITS=2, so ROWS=8 and IDX_BITS=3.
1. Release reset → ready_o low for 8 cycles, high on cycle 8. Before then valid_o=0 and taken_o=0. Afterwards, any index gives valid_o=0 and taken_o=2'b11 (counters at 2'b10).
2. Update index 5, row 1: three taken updates take the counter 10→11→11. Then three not-taken updates take it 10→01→00. Reading index 5 gives valid_o[1]=1, taken_o[1]=0, and column 0 untouched.
3. From ghr=0, shift 1,0,1 → ghr_o=3'b101. With pc_idx=3'b011 → index_o=3'b110.
4. Same cycle: mispredict restore with update_ghr_i=3'b011, update_taken_i=0, plus ghr_shift_i=1 with ghr_shift_taken_i=1 → ghr_o=3'b110 next cycle.
5. debug_mode_i=1 with a taken mispredicting update on index 2 → counter unchanged (valid stays 0), but the GHR restore is applied.
6. flush_bp_i in READY after training → ready_o=0 for 8 cycles and ghr_o=0. A second flush 4 cycles in restarts the sweep (8 more cycles). Updates issued during INIT have no effect, and all entries read valid=0 afterwards.
